// File: rtl/unified_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-cycle-latency memory, alternating priority on conflict.
// Optional grant/conflict counters are built when the ARB_STATS_EN macro is defined.
module unified_mem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
`ifdef ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_if_cnt,
  output logic [15:0]   stat_d_cnt,
  output logic [15:0]   stat_conf_cnt,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        r_state;
  logic          r_winD;
  logic          r_lastD;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_ifGnt;
  logic          r_dGnt;
  logic          r_ifValid;
  logic          r_dValid;
  logic          r_mEn;
  logic          r_mWe;

  logic w_arb;
  logic w_anyReq;
  logic w_pickD;

  // Requests are only looked at outside ACC, so a requester still holding req in its gnt cycle is ignored
  assign w_arb    = (r_state != ACC);
  assign w_anyReq = if_req | d_req;
  assign w_pickD  = d_req & (~if_req | ~r_lastD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_winD    <= 1'b0;
      r_lastD   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ifGnt   <= 1'b0;
      r_dGnt    <= 1'b0;
      r_ifValid <= 1'b0;
      r_dValid  <= 1'b0;
      r_mEn     <= 1'b0;
      r_mWe     <= 1'b0;
    end else begin
      r_ifGnt   <= 1'b0;
      r_dGnt    <= 1'b0;
      r_ifValid <= 1'b0;
      r_dValid  <= 1'b0;
      r_mEn     <= 1'b0;
      r_mWe     <= 1'b0;
      case (r_state)
        ACC: begin
          r_state   <= RESP;
          r_ifValid <= ~r_winD;
          r_dValid  <= r_winD;
        end
        default: begin
          if (w_anyReq) begin
            r_state <= ACC;
            r_winD  <= w_pickD;
            r_lastD <= w_pickD;
            r_addr  <= w_pickD ? d_addr : if_addr;
            r_wdata <= w_pickD ? d_wdata : '0;
            r_ifGnt <= ~w_pickD;
            r_dGnt  <= w_pickD;
            r_mEn   <= 1'b1;
            r_mWe   <= w_pickD & d_we;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign if_gnt   = r_ifGnt;
  assign d_gnt    = r_dGnt;
  assign if_valid = r_ifValid;
  assign d_valid  = r_dValid;
  assign m_en     = r_mEn;
  assign m_we     = r_mWe;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign busy     = (r_state != IDLE);

  // Memory read data flows straight through to the winner in the response cycle
  assign if_rdata = r_ifValid ? m_rdata : '0;
  assign d_rdata  = r_dValid  ? m_rdata : '0;

`ifdef ARB_STATS_EN
  logic [15:0] r_ifCnt;
  logic [15:0] r_dCnt;
  logic [15:0] r_confCnt;
  logic        w_conf;

  assign w_conf = w_arb & if_req & d_req;

  // Saturating counters; a clear in the same cycle as an event discards the event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifCnt   <= '0;
      r_dCnt    <= '0;
      r_confCnt <= '0;
    end else if (stat_clr) begin
      r_ifCnt   <= '0;
      r_dCnt    <= '0;
      r_confCnt <= '0;
    end else begin
      if (r_ifGnt && (r_ifCnt != 16'hFFFF))
        r_ifCnt <= r_ifCnt + 16'd1;
      if (r_dGnt && (r_dCnt != 16'hFFFF))
        r_dCnt <= r_dCnt + 16'd1;
      if (w_conf && (r_confCnt != 16'hFFFF))
        r_confCnt <= r_confCnt + 16'd1;
    end
  end

  assign stat_if_cnt   = r_ifCnt;
  assign stat_d_cnt    = r_dCnt;
  assign stat_conf_cnt = r_confCnt;
`endif

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: AW, 6, address width shared by fetch, data and memory ports.
REQ-002 Parameter: DW, 16, data/instruction word width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: if_req  input  1  fetch request, held high until if_gnt.
REQ-006 Port: if_addr  input  AW  fetch address (PC).
REQ-007 Port: if_gnt  output  1  fetch grant, one-cycle pulse.
REQ-008 Port: if_valid  output  1  fetch data valid, one-cycle pulse.
REQ-009 Port: if_rdata  output  DW  fetched instruction, meaningful when if_valid.
REQ-010 Port: d_req  input  1  data request, held high until d_gnt.
REQ-011 Port: d_we  input  1  data write (1) / read (0).
REQ-012 Port: d_addr  input  AW  data address.
REQ-013 Port: d_wdata  input  DW  store data.
REQ-014 Port: d_gnt  output  1  data grant, one-cycle pulse.
REQ-015 Port: d_valid  output  1  data completion pulse (read data or write done).
REQ-016 Port: d_rdata  output  DW  load data, meaningful when d_valid and read.
REQ-017 Port: m_en  output  1  memory access enable.
REQ-018 Port: m_we  output  1  memory write enable.
REQ-019 Port: m_addr  output  AW  memory address.
REQ-020 Port: m_wdata  output  DW  memory write data.
REQ-021 Port: m_rdata  input  DW  memory read data, valid one cycle after m_en.
REQ-022 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states: IDLE, ACC (memory access cycle), RESP (response cycle).
REQ-024 IDLE: if either req high at edge, go to ACC, latch winner's addr/we/wdata, pulse winner's gnt in the ACC cycle; else stay IDLE.
REQ-025 ACC: m_en=1, m_addr/m_we/m_wdata from latched request; next state RESP.
REQ-026 RESP: winner's valid=1, rdata=m_rdata (registered capture not permitted; data passes through in this cycle); arbitration repeats as in IDLE, going to ACC if a req is high, else IDLE.
REQ-027 Latency: req sampled at edge N -> gnt and m_en in cycle N+1 -> valid in cycle N+2; back-to-back throughput one access per 2 cycles.
REQ-028 Arbitration when both req high: grant data unless last grant was data, in which case grant fetch (alternating round-robin); single requester always granted.
REQ-029 last_grant flag updates only on a grant.
REQ-030 Requests are not re-sampled during ACC; a req still high in its own gnt cycle is not treated as a new request.
REQ-031 Only one transaction outstanding; gnt and valid are never high for both ports in the same cycle.
REQ-032 m_en, m_we, gnt and valid outputs are 0 in every cycle not specified above; m_we=0 for fetch accesses.
REQ-033 d_valid pulses for writes as well as reads; d_rdata for writes is don't-care.

Reset
REQ-034 rst low immediately forces state IDLE, last_grant=fetch (so data wins the first conflict), all outputs 0, latched request cleared.
REQ-035 Reset asserted mid-transaction drops it: no valid is issued for it after reset release.
REQ-036 First arbitration occurs at the first rising edge after rst deasserts.

Configuration
REQ-037 Macro ARB_STATS_EN defined: ports stat_clr input 1, stat_if_cnt output 16, stat_d_cnt output 16, stat_conf_cnt output 16 added.
REQ-038 With ARB_STATS_EN: counters increment on if_gnt, d_gnt, and arbitration cycles with both reqs high respectively, saturate at 16'hFFFF, clear to 0 on stat_clr (synchronous) or reset; stat_clr wins over increment.
REQ-039 Without ARB_STATS_EN: stat ports and counters absent; all other behaviour identical.

Verification
REQ-040 Fetch only: if_req=1, if_addr=6'h05, m_rdata=16'h1234 in RESP -> if_gnt cycle 1, m_en/m_addr=05 cycle 1, if_valid with if_rdata=1234 cycle 2.
REQ-041 Conflict after reset: both req, d_addr=6'h10, if_addr=6'h00 -> data granted first, fetch granted in RESP cycle of data, alternating thereafter.
REQ-042 Store: d_req=1, d_we=1, d_addr=6'h3F, d_wdata=16'hBEEF -> m_en=m_we=1, m_addr=3F, m_wdata=BEEF in ACC; d_valid next cycle.
REQ-043 Reset mid-ACC: rst low during ACC of fetch -> all outputs 0 at once, no if_valid after release, busy=0.
REQ-044 Continuous fetch: if_req held with new address each grant -> one access every 2 cycles, busy stays 1.
REQ-045 ARB_STATS_EN: 3 conflicts, then stat_clr with simultaneous grant -> stat_conf_cnt=3 before clear, all counters 0 after.
